// File: rtl/serial_match_scheduler.sv
// ============================================================================
// Module   : serial_match_scheduler
// Purpose  : Round-robin share of one serial 1011 detector between two
//            requesters; returns a per-transaction match count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_match_scheduler #(
   parameter int NBITS = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [NBITS-1:0] word_a,
   input  logic [NBITS-1:0] word_b,
   output logic [1:0]       grant,
   output logic             busy,
   output logic [1:0]       done,
   output logic [CNT_W-1:0] match_count,
   output logic             det_reset,
   output logic             det_data_in,
   input  logic             det_match
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_SHIFT = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(NBITS - 1);

   state_t             state_q;
   logic [NBITS-1:0]   shreg_q;
   logic [CNT_W-1:0]   bitcnt_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   match_count_q;
   logic [1:0]         grant_q;
   logic [1:0]         done_q;
   logic               busy_q;
   logic               rr_q;
   logic               owner_q;

   logic               pick_d;
   logic               sample_d;
   logic [CNT_W-1:0]   count_inc_d;

   always_comb begin
      pick_d = (req == 2'b11) ? rr_q : req[1];
      // The detector's output trails the shifted bit by one cycle, so the
      // first SHIFT cycle still shows the cleared value and is skipped.
      sample_d = ((state_q == S_SHIFT) && (bitcnt_q != '0)) || (state_q == S_DRAIN);
      count_inc_d = (count_q == C_CNT_MAX) ? count_q : count_q + 1'b1;
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q       <= S_IDLE;
         shreg_q       <= '0;
         bitcnt_q      <= '0;
         count_q       <= '0;
         match_count_q <= '0;
         grant_q       <= 2'b00;
         done_q        <= 2'b00;
         busy_q        <= 1'b0;
         rr_q          <= 1'b0;
         owner_q       <= 1'b0;
      end else begin
         done_q <= 2'b00;
         case (state_q)
            S_IDLE: begin
               if (req != 2'b00) begin
                  owner_q <= pick_d;
                  grant_q <= pick_d ? 2'b10 : 2'b01;
                  shreg_q <= pick_d ? word_b : word_a;
                  busy_q  <= 1'b1;
                  state_q <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               count_q  <= '0;
               bitcnt_q <= '0;
               state_q  <= S_SHIFT;
            end
            S_SHIFT: begin
               shreg_q  <= shreg_q >> 1;
               bitcnt_q <= bitcnt_q + 1'b1;
               if (sample_d && det_match) begin
                  count_q <= count_inc_d;
               end
               if (bitcnt_q == C_LAST_BIT) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Fold in the last sample so the result is valid alongside done.
               match_count_q <= (sample_d && det_match) ? count_inc_d : count_q;
               done_q        <= grant_q;
               state_q       <= S_DONE;
            end
            S_DONE: begin
               grant_q <= 2'b00;
               busy_q  <= 1'b0;
               rr_q    <= ~owner_q;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign match_count = match_count_q;
   assign det_reset   = reset | (state_q == S_CLEAR);
   assign det_data_in = (state_q == S_SHIFT) & shreg_q[0];

endmodule

`default_nettype wire

// File: tb/tb_serial_match_scheduler.sv
// ============================================================================
// Module   : tb_serial_match_scheduler
// Purpose  : Directed bench with a 1011 sticky detector on the detector port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_match_scheduler;

   localparam int NBITS = 8;
   localparam int CNT_W = 4;

   logic             clk_2;
   logic             reset;
   logic [1:0]       req;
   logic [NBITS-1:0] word_a;
   logic [NBITS-1:0] word_b;
   logic [1:0]       grant;
   logic             busy;
   logic [1:0]       done;
   logic [CNT_W-1:0] match_count;
   logic             det_reset;
   logic             det_data_in;
   logic             det_match;
   logic [2:0]       det_hist;

   int errors = 0;
   int checks = 0;

   serial_match_scheduler #(.NBITS(NBITS), .CNT_W(CNT_W)) u_dut (
      .clk_2       (clk_2),
      .reset       (reset),
      .req         (req),
      .word_a      (word_a),
      .word_b      (word_b),
      .grant       (grant),
      .busy        (busy),
      .done        (done),
      .match_count (match_count),
      .det_reset   (det_reset),
      .det_data_in (det_data_in),
      .det_match   (det_match)
   );

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   // Sticky 1011 detector: bits arrive oldest-first, match once the last
   // four bits read 1,0,1,1 and hold until reset.
   always_ff @(posedge clk_2) begin
      if (det_reset) begin
         det_hist  <= 3'b000;
         det_match <= 1'b0;
      end else begin
         det_hist <= {det_hist[1:0], det_data_in};
         if ({det_hist, det_data_in} == 4'b1011) begin
            det_match <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_2);
      #1;
   endtask

   // Called in IDLE cycle 0 with req already driven; returns in cycle 12.
   task automatic txn(input logic [1:0] exp_g, input logic [CNT_W-1:0] exp_cnt,
                      input logic drop);
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk("grant_not_both", 32'(grant == 2'b11), 32'd0);
         if (drop && c == 4) begin
            req    = 2'b00;
            word_a = 8'h00;
         end
         case (c)
            1: begin
               chk("grant_c1", 32'(grant), 32'(exp_g));
               chk("busy_c1", 32'(busy), 32'd1);
               chk("detrst_c1", 32'(det_reset), 32'd1);
            end
            2:  chk("detrst_c2", 32'(det_reset), 32'd0);
            6:  chk("detrst_c6", 32'(det_reset), 32'd0);
            10: chk("done_c10", 32'(done), 32'd0);
            11: chk("done_c11", 32'(done), 32'(exp_g));
            12: begin
               chk("grant_c12", 32'(grant), 32'd0);
               chk("busy_c12", 32'(busy), 32'd0);
               chk("done_c12", 32'(done), 32'd0);
               chk("count_c12", 32'(match_count), 32'(exp_cnt));
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      reset  = 1'b1;
      req    = 2'b00;
      word_a = '0;
      word_b = '0;

      tick();
      tick();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(match_count), 32'd0);
      chk("rst_detrst", 32'(det_reset), 32'd1);

      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_grant", 32'(grant), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_detrst", 32'(det_reset), 32'd0);
      end

      // Single requesters: 0x0D -> 5, 0xFF -> 0, 0xD0 -> 1 (DRAIN sample only).
      req = 2'b01; word_a = 8'h0D;
      txn(2'b01, 4'd5, 1'b0);
      req = 2'b10; word_b = 8'hFF;
      txn(2'b10, 4'd0, 1'b0);
      word_b = 8'hD0;
      txn(2'b10, 4'd1, 1'b0);
      req = 2'b00;
      tick();

      // Round robin from reset with both requesting continuously.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0; req = 2'b11; word_a = 8'h0D; word_b = 8'hD0;
      txn(2'b01, 4'd5, 1'b0);
      txn(2'b10, 4'd1, 1'b0);
      txn(2'b01, 4'd5, 1'b0);
      req = 2'b00;
      tick();

      // Reset during the 4th SHIFT cycle aborts the transaction.
      req = 2'b01; word_a = 8'h0D;
      tick();
      req = 2'b00;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      #1;
      chk("abort_detrst", 32'(det_reset), 32'd1);
      tick();
      chk("abort_grant", 32'(grant), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_count", 32'(match_count), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("abort_no_done", 32'(done), 32'd0);
      end

      req = 2'b01; word_a = 8'h0D;
      txn(2'b01, 4'd5, 1'b0);

      // Drop req and change the word mid-transaction; latched word is used.
      req = 2'b10; word_b = 8'hFF;
      txn(2'b10, 4'd0, 1'b0);
      req = 2'b01; word_a = 8'h0D;
      txn(2'b01, 4'd5, 1'b1);
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("drop_no_grant", 32'(grant), 32'd0);
         chk("drop_no_done", 32'(done), 32'd0);
      end
      chk("drop_count_hold", 32'(match_count), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
